gfx256_rd_arbiter: RTL and testbench

Round-robin arbiter that shares the single wishbone-master read port among three read clients: z-buffer reads from the clip stage, texture reads from the fragment stage, and destination reads from the blender. It grants one client at a time and holds that grant for the whole transaction. It latches the granted client's address and byte-select, forwards the returned memory line, and drives a per-client busy flag. It sits between the pipeline stages and the wbm reader.

---
 rtl/gfx256_rd_arbiter_if.sv | 66 ++++++
 rtl/gfx256_rd_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_gfx256_rd_arbiter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gfx256_rd_arbiter_if.sv
// Bundle of every signal between gfx256_rd_arbiter, its three read clients
// (z-buffer, texture, blender) and the wbm reader.
// The master modport is the arbiter's view. The slave modport is the view of
// the surrounding pipeline and reader.
interface gfx256_rd_arbiter_if #(
  parameter int MDW = 256
);

  // client side: z-buffer reads from the clip stage
  logic            z_request_i;
  logic [31:0]     z_addr_i;
  logic [31:0]     z_sel_i;
  logic            z_ack_o;
  logic            z_busy_o;

  // client side: texture reads from the fragment stage
  logic            tex_request_i;
  logic [31:0]     tex_addr_i;
  logic [31:0]     tex_sel_i;
  logic            tex_ack_o;
  logic            tex_busy_o;

  // client side: destination reads from the blender
  logic            blend_request_i;
  logic [31:0]     blend_addr_i;
  logic [31:0]     blend_sel_i;
  logic            blend_ack_o;
  logic            blend_busy_o;

  // shared returned line and current owner
  logic [MDW-1:0]  data_o;
  logic [1:0]      grant_o;

  // reader side
  logic            m_request_o;
  logic [31:0]     m_addr_o;
  logic [31:0]     m_sel_o;
  logic            m_ack_i;
  logic [MDW-1:0]  m_data_i;
  logic            m_busy_i;

  modport master (
    input  z_request_i, z_addr_i, z_sel_i,
    input  tex_request_i, tex_addr_i, tex_sel_i,
    input  blend_request_i, blend_addr_i, blend_sel_i,
    output z_ack_o, z_busy_o,
    output tex_ack_o, tex_busy_o,
    output blend_ack_o, blend_busy_o,
    output data_o, grant_o,
    output m_request_o, m_addr_o, m_sel_o,
    input  m_ack_i, m_data_i, m_busy_i
  );

  modport slave (
    output z_request_i, z_addr_i, z_sel_i,
    output tex_request_i, tex_addr_i, tex_sel_i,
    output blend_request_i, blend_addr_i, blend_sel_i,
    input  z_ack_o, z_busy_o,
    input  tex_ack_o, tex_busy_o,
    input  blend_ack_o, blend_busy_o,
    input  data_o, grant_o,
    input  m_request_o, m_addr_o, m_sel_o,
    output m_ack_i, m_data_i, m_busy_i
  );

endinterface

// File: rtl/gfx256_rd_arbiter.sv
// gfx256_rd_arbiter: round-robin owner of the single wbm read port, shared by
// the z-buffer, texture and blender read clients.
// One client owns the port for the whole transaction. Its address and
// byte select are latched at grant time. The returned line is registered into
// data_o, and the owner gets a one-cycle ack. A mandatory RELEASE cycle gives
// the served client time to drop its request before the next arbitration.
module gfx256_rd_arbiter #(
  parameter int MDW = 256
) (
  input  logic               clk_i,
  input  logic               rst_i,
  gfx256_rd_arbiter_if.master bus
);

  // client encoding shared by grant_o, last_grant and the request vector
  localparam logic [1:0] CL_Z     = 2'd0;
  localparam logic [1:0] CL_TEX   = 2'd1;
  localparam logic [1:0] CL_BLEND = 2'd2;
  localparam logic [1:0] CL_NONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      last_grant_q, last_grant_d;
  logic [1:0]      grant_q, grant_d;
  logic            m_request_q, m_request_d;
  logic [31:0]     m_addr_q, m_addr_d;
  logic [31:0]     m_sel_q, m_sel_d;
  logic [MDW-1:0]  data_q, data_d;
  logic [2:0]      ack_q, ack_d;

  // The top bit is a constant zero, so an index of 3 (no owner) reads as "not requesting".
  logic [3:0]      req_vec;
  logic            pick_valid;
  logic [1:0]      pick;
  logic [31:0]     pick_addr;
  logic [31:0]     pick_sel;
  logic            owner_req;
  logic [2:0]      owner_onehot;

  assign req_vec = {1'b0, bus.blend_request_i, bus.tex_request_i, bus.z_request_i};

  // Rotation order z -> tex -> blend -> z. "None" restarts at z.
  function automatic logic [1:0] next_client(input logic [1:0] c);
    case (c)
      CL_Z:    next_client = CL_TEX;
      CL_TEX:  next_client = CL_BLEND;
      default: next_client = CL_Z;
    endcase
  endfunction

  // One-hot ack position for a client. The "none" code maps to no ack.
  function automatic logic [2:0] client_onehot(input logic [1:0] c);
    case (c)
      CL_Z:     client_onehot = 3'b001;
      CL_TEX:   client_onehot = 3'b010;
      CL_BLEND: client_onehot = 3'b100;
      default:  client_onehot = 3'b000;
    endcase
  endfunction

  // Search for a winner, starting at the client after last_grant and wrapping.
  always_comb begin
    logic [1:0] cand;
    pick_valid = 1'b0;
    pick       = CL_Z;
    cand       = last_grant_q;
    for (int i = 0; i < 3; i++) begin
      cand = next_client(cand);
      if (!pick_valid && req_vec[cand]) begin
        pick_valid = 1'b1;
        pick       = cand;
      end
    end
  end

  // Select the address and byte select of the winning client for latching.
  always_comb begin
    pick_addr = bus.z_addr_i;
    pick_sel  = bus.z_sel_i;
    case (pick)
      CL_TEX: begin
        pick_addr = bus.tex_addr_i;
        pick_sel  = bus.tex_sel_i;
      end
      CL_BLEND: begin
        pick_addr = bus.blend_addr_i;
        pick_sel  = bus.blend_sel_i;
      end
      default: begin
        pick_addr = bus.z_addr_i;
        pick_sel  = bus.z_sel_i;
      end
    endcase
  end

  // A withdrawn owner request swallows the ack, but the line is still captured.
  assign owner_req    = req_vec[grant_q];
  assign owner_onehot = client_onehot(grant_q);

  // Next-state and registered-output logic for the grant FSM.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    m_request_d  = m_request_q;
    m_addr_d     = m_addr_q;
    m_sel_d      = m_sel_q;
    data_d       = data_q;
    ack_d        = 3'b000;
    case (state_q)
      IDLE: begin
        m_request_d = 1'b0;
        if (pick_valid && !bus.m_busy_i) begin
          state_d      = ISSUE;
          grant_d      = pick;
          last_grant_d = pick;
          m_request_d  = 1'b1;
          m_addr_d     = pick_addr;
          m_sel_d      = pick_sel;
        end
      end
      ISSUE: begin
        m_request_d = 1'b1;
        if (bus.m_ack_i) begin
          data_d      = bus.m_data_i;
          ack_d       = owner_req ? owner_onehot : 3'b000;
          m_request_d = 1'b0;
          state_d     = RELEASE;
        end
      end
      RELEASE: begin
        m_request_d = 1'b0;
        grant_d     = CL_NONE;
        state_d     = IDLE;
      end
      default: begin
        m_request_d = 1'b0;
        grant_d     = CL_NONE;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers. Reset clears any in-flight transaction at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= CL_BLEND;
      grant_q      <= CL_NONE;
      m_request_q  <= 1'b0;
      m_addr_q     <= '0;
      m_sel_q      <= '0;
      data_q       <= '0;
      ack_q        <= 3'b000;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      m_request_q  <= m_request_d;
      m_addr_q     <= m_addr_d;
      m_sel_q      <= m_sel_d;
      data_q       <= data_d;
      ack_q        <= ack_d;
    end
  end

  assign bus.m_request_o = m_request_q;
  assign bus.m_addr_o    = m_addr_q;
  assign bus.m_sel_o     = m_sel_q;
  assign bus.data_o      = data_q;
  assign bus.grant_o     = grant_q;
  assign bus.z_ack_o     = ack_q[0];
  assign bus.tex_ack_o   = ack_q[1];
  assign bus.blend_ack_o = ack_q[2];

  // A client is busy when the reader is busy, or when a transaction is in flight for another client.
  assign bus.z_busy_o     = bus.m_busy_i | ((state_q != IDLE) && (grant_q != CL_Z));
  assign bus.tex_busy_o   = bus.m_busy_i | ((state_q != IDLE) && (grant_q != CL_TEX));
  assign bus.blend_busy_o = bus.m_busy_i | ((state_q != IDLE) && (grant_q != CL_BLEND));

endmodule

// File: tb/tb_gfx256_rd_arbiter.sv
// Directed bench for gfx256_rd_arbiter. Inputs are driven and outputs sampled
// on the falling clock edge. The bench acts as the reader, answering
// m_request_o after a chosen latency.
module tb_gfx256_rd_arbiter;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   ack_pulses;

  gfx256_rd_arbiter_if #(.MDW(256)) bus ();

  gfx256_rd_arbiter #(.MDW(256)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // at most one client ack per cycle, and a tally of ack pulses seen
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ($countones({bus.blend_ack_o, bus.tex_ack_o, bus.z_ack_o}) > 1) begin
        errors++;
        $display("[TB] FAIL ack_onehot: got %b want at most one bit",
                 {bus.blend_ack_o, bus.tex_ack_o, bus.z_ack_o});
      end
      ack_pulses += $countones({bus.blend_ack_o, bus.tex_ack_o, bus.z_ack_o});
    end
  end

  // hard stop in case something never terminates
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Wait (bounded) for the arbiter to raise m_request_o. The caller is on a negedge.
  task automatic wait_m_request(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.m_request_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Reader acks lat cycles after m_request_o was first seen. Returns on the negedge after the ack edge.
  task automatic reader_ack(input int lat, input logic [255:0] line);
    repeat (lat - 1) @(negedge clk);
    bus.m_ack_i  = 1'b1;
    bus.m_data_i = line;
    @(negedge clk);
    bus.m_ack_i  = 1'b0;
    bus.m_data_i = '0;
  endtask

  // synchronous-looking reset pulse between scenarios
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (bus.m_request_o !== 1'b0 || bus.grant_o !== 2'd3) begin
      errors++;
      $display("[TB] FAIL reset_held: got req=%b grant=%0d want req=0 grant=3",
               bus.m_request_o, bus.grant_o);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.grant_o !== 2'd3) begin
      errors++;
      $display("[TB] FAIL reset_grant: got %0d want 3", bus.grant_o);
    end
    checks++;
    if (bus.m_addr_o !== 32'h0 || bus.m_sel_o !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_addr_sel: got %h/%h want 0/0", bus.m_addr_o, bus.m_sel_o);
    end
    checks++;
    if (bus.data_o !== 256'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h want 0", bus.data_o);
    end
    checks++;
    if ({bus.blend_ack_o, bus.tex_ack_o, bus.z_ack_o} !== 3'b000 || bus.m_request_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ack_req: got ack=%b req=%b want 000/0",
               {bus.blend_ack_o, bus.tex_ack_o, bus.z_ack_o}, bus.m_request_o);
    end
    checks++;
    if ({bus.blend_busy_o, bus.tex_busy_o, bus.z_busy_o} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_busy_low: got %b want 000",
               {bus.blend_busy_o, bus.tex_busy_o, bus.z_busy_o});
    end
    bus.m_busy_i = 1'b1;
    #1;
    checks++;
    if ({bus.blend_busy_o, bus.tex_busy_o, bus.z_busy_o} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL reset_busy_follow: got %b want 111",
               {bus.blend_busy_o, bus.tex_busy_o, bus.z_busy_o});
    end
    bus.m_busy_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_z();
    bit seen;
    logic [255:0] line;
    line = {32{8'hA5}};
    bus.z_addr_i    = 32'h0000_1000;
    bus.z_sel_i     = 32'hFFFF_FFFF;
    bus.z_request_i = 1'b1;
    wait_m_request(seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL single_req: got no m_request_o want 1");
    end
    checks++;
    if (bus.m_addr_o !== 32'h0000_1000 || bus.m_sel_o !== 32'hFFFF_FFFF || bus.grant_o !== 2'd0) begin
      errors++;
      $display("[TB] FAIL single_latch: got addr=%h sel=%h grant=%0d want 1000/ffffffff/0",
               bus.m_addr_o, bus.m_sel_o, bus.grant_o);
    end
    bus.z_addr_i = 32'hDEAD_0000;
    bus.z_sel_i  = 32'h0;
    @(negedge clk);
    checks++;
    if (bus.m_addr_o !== 32'h0000_1000 || bus.m_sel_o !== 32'hFFFF_FFFF || bus.m_request_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_hold: got addr=%h sel=%h req=%b want 1000/ffffffff/1",
               bus.m_addr_o, bus.m_sel_o, bus.m_request_o);
    end
    reader_ack(2, line);
    checks++;
    if ({bus.blend_ack_o, bus.tex_ack_o, bus.z_ack_o} !== 3'b001 || bus.data_o !== line) begin
      errors++;
      $display("[TB] FAIL single_ack: got ack=%b data=%h want 001 data=%h",
               {bus.blend_ack_o, bus.tex_ack_o, bus.z_ack_o}, bus.data_o, line);
    end
    bus.z_request_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.blend_ack_o, bus.tex_ack_o, bus.z_ack_o} !== 3'b000 || bus.grant_o !== 2'd3 || bus.m_request_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_release: got ack=%b grant=%0d req=%b want 000/3/0",
               {bus.blend_ack_o, bus.tex_ack_o, bus.z_ack_o}, bus.grant_o, bus.m_request_o);
    end
  endtask

  task automatic test_simultaneous();
    bit seen;
    int start_pulses;
    logic [255:0] line;
    logic [31:0] exp_addr [3];
    exp_addr[0] = 32'h0000_0100;
    exp_addr[1] = 32'h0000_0200;
    exp_addr[2] = 32'h0000_0300;
    do_reset();
    start_pulses        = ack_pulses;
    bus.z_addr_i        = exp_addr[0];
    bus.tex_addr_i      = exp_addr[1];
    bus.blend_addr_i    = exp_addr[2];
    bus.z_sel_i         = 32'h0000_000F;
    bus.tex_sel_i       = 32'h0000_00F0;
    bus.blend_sel_i     = 32'h0000_0F00;
    bus.z_request_i     = 1'b1;
    bus.tex_request_i   = 1'b1;
    bus.blend_request_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      line = {8{32'h1111_0000 + 32'(k)}};
      wait_m_request(seen);
      checks++;
      if (!seen || bus.grant_o !== 2'(k) || bus.m_addr_o !== exp_addr[k]) begin
        errors++;
        $display("[TB] FAIL simul_grant%0d: got seen=%b grant=%0d addr=%h want 1/%0d/%h",
                 k, seen, bus.grant_o, bus.m_addr_o, k, exp_addr[k]);
      end
      reader_ack(1, line);
      checks++;
      if ({bus.blend_ack_o, bus.tex_ack_o, bus.z_ack_o} !== (3'b001 << k) || bus.data_o !== line) begin
        errors++;
        $display("[TB] FAIL simul_ack%0d: got ack=%b data=%h want %b data=%h",
                 k, {bus.blend_ack_o, bus.tex_ack_o, bus.z_ack_o}, bus.data_o, 3'b001 << k, line);
      end
      case (k)
        0:       bus.z_request_i     = 1'b0;
        1:       bus.tex_request_i   = 1'b0;
        default: bus.blend_request_i = 1'b0;
      endcase
      @(negedge clk);
    end
    checks++;
    if (ack_pulses - start_pulses !== 3) begin
      errors++;
      $display("[TB] FAIL simul_ack_count: got %0d want 3", ack_pulses - start_pulses);
    end
  endtask

  task automatic test_fairness();
    bit seen;
    logic [255:0] line;
    logic [1:0] exp_grant [4];
    exp_grant[0] = 2'd1;
    exp_grant[1] = 2'd2;
    exp_grant[2] = 2'd1;
    exp_grant[3] = 2'd2;
    bus.tex_request_i   = 1'b1;
    bus.blend_request_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      line = {8{32'hF00D_0000 + 32'(k)}};
      wait_m_request(seen);
      checks++;
      if (!seen || bus.grant_o !== exp_grant[k]) begin
        errors++;
        $display("[TB] FAIL fair_grant%0d: got seen=%b grant=%0d want 1/%0d",
                 k, seen, bus.grant_o, exp_grant[k]);
      end
      reader_ack(1, line);
      checks++;
      if ({bus.blend_ack_o, bus.tex_ack_o, bus.z_ack_o} !== (3'b001 << exp_grant[k])) begin
        errors++;
        $display("[TB] FAIL fair_ack%0d: got %b want %b",
                 k, {bus.blend_ack_o, bus.tex_ack_o, bus.z_ack_o}, 3'b001 << exp_grant[k]);
      end
      @(negedge clk);
    end
    bus.tex_request_i   = 1'b0;
    bus.blend_request_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reader_busy();
    int bad;
    logic [255:0] line;
    line = {8{32'hB05E_B05E}};
    bad  = 0;
    bus.m_busy_i    = 1'b1;
    bus.z_addr_i    = 32'h0000_4000;
    bus.z_request_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus.m_request_o !== 1'b0 || bus.z_busy_o !== 1'b1) begin
        errors++;
        $display("[TB] FAIL busy_block%0d: got req=%b z_busy=%b want 0/1",
                 i, bus.m_request_o, bus.z_busy_o);
      end
    end
    bus.m_busy_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.m_request_o !== 1'b1 || bus.grant_o !== 2'd0 || bus.m_addr_o !== 32'h0000_4000 || bus.z_busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_release_grant: got req=%b grant=%0d addr=%h z_busy=%b want 1/0/4000/0",
               bus.m_request_o, bus.grant_o, bus.m_addr_o, bus.z_busy_o);
    end
    reader_ack(1, line);
    checks++;
    if (bus.z_ack_o !== 1'b1 || bus.data_o !== line) begin
      errors++;
      $display("[TB] FAIL busy_ack: got ack=%b data=%h want 1 data=%h", bus.z_ack_o, bus.data_o, line);
    end
    bus.z_request_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_withdrawn();
    bit seen;
    logic [255:0] line;
    line = {8{32'hC0FF_EE00}};
    bus.tex_addr_i    = 32'h0000_5000;
    bus.tex_request_i = 1'b1;
    wait_m_request(seen);
    checks++;
    if (!seen || bus.grant_o !== 2'd1) begin
      errors++;
      $display("[TB] FAIL withdraw_grant: got seen=%b grant=%0d want 1/1", seen, bus.grant_o);
    end
    @(negedge clk);
    @(negedge clk);
    bus.tex_request_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.m_request_o !== 1'b1) begin
        errors++;
        $display("[TB] FAIL withdraw_hold%0d: got req=%b want 1", i, bus.m_request_o);
      end
    end
    reader_ack(1, line);
    checks++;
    if ({bus.blend_ack_o, bus.tex_ack_o, bus.z_ack_o} !== 3'b000 || bus.data_o !== line) begin
      errors++;
      $display("[TB] FAIL withdraw_swallow: got ack=%b data=%h want 000 data=%h",
               {bus.blend_ack_o, bus.tex_ack_o, bus.z_ack_o}, bus.data_o, line);
    end
    @(negedge clk);
    checks++;
    if (bus.m_request_o !== 1'b0 || bus.grant_o !== 2'd3 ||
        {bus.blend_busy_o, bus.tex_busy_o, bus.z_busy_o} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL withdraw_idle: got req=%b grant=%0d busy=%b want 0/3/000",
               bus.m_request_o, bus.grant_o, {bus.blend_busy_o, bus.tex_busy_o, bus.z_busy_o});
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    logic [255:0] line;
    line = {8{32'h7777_0001}};
    bus.z_addr_i    = 32'h0000_6000;
    bus.z_request_i = 1'b1;
    wait_m_request(seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL areset_pre_req: got no m_request_o want 1");
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.m_request_o !== 1'b0 || bus.grant_o !== 2'd3) begin
      errors++;
      $display("[TB] FAIL areset_immediate: got req=%b grant=%0d want 0/3", bus.m_request_o, bus.grant_o);
    end
    bus.z_request_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus.m_ack_i  = 1'b1;
    bus.m_data_i = {8{32'hBAD0_BAD0}};
    @(negedge clk);
    bus.m_ack_i  = 1'b0;
    bus.m_data_i = '0;
    @(negedge clk);
    checks++;
    if ({bus.blend_ack_o, bus.tex_ack_o, bus.z_ack_o} !== 3'b000 || bus.m_request_o !== 1'b0 || bus.data_o !== 256'h0) begin
      errors++;
      $display("[TB] FAIL areset_stray_ack: got ack=%b req=%b data=%h want 000/0/0",
               {bus.blend_ack_o, bus.tex_ack_o, bus.z_ack_o}, bus.m_request_o, bus.data_o);
    end
    bus.z_addr_i    = 32'h0000_7000;
    bus.z_request_i = 1'b1;
    wait_m_request(seen);
    checks++;
    if (!seen || bus.grant_o !== 2'd0 || bus.m_addr_o !== 32'h0000_7000) begin
      errors++;
      $display("[TB] FAIL areset_regrant: got seen=%b grant=%0d addr=%h want 1/0/7000",
               seen, bus.grant_o, bus.m_addr_o);
    end
    reader_ack(2, line);
    checks++;
    if (bus.z_ack_o !== 1'b1 || bus.data_o !== line) begin
      errors++;
      $display("[TB] FAIL areset_serve: got ack=%b data=%h want 1 data=%h", bus.z_ack_o, bus.data_o, line);
    end
    bus.z_request_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.grant_o !== 2'd3) begin
      errors++;
      $display("[TB] FAIL areset_final_grant: got %0d want 3", bus.grant_o);
    end
  endtask

  // scenario sequence
  initial begin
    errors              = 0;
    checks              = 0;
    ack_pulses          = 0;
    rst                 = 1'b1;
    bus.z_request_i     = 1'b0;
    bus.tex_request_i   = 1'b0;
    bus.blend_request_i = 1'b0;
    bus.z_addr_i        = '0;
    bus.tex_addr_i      = '0;
    bus.blend_addr_i    = '0;
    bus.z_sel_i         = '0;
    bus.tex_sel_i       = '0;
    bus.blend_sel_i     = '0;
    bus.m_ack_i         = 1'b0;
    bus.m_data_i        = '0;
    bus.m_busy_i        = 1'b0;
    $display("[TB] starting gfx256_rd_arbiter bench");
    test_reset();
    test_single_z();
    test_simultaneous();
    test_fairness();
    test_reader_busy();
    test_withdrawn();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
